tick_gen: RTL
=============

# tick_gen

Parametrised, synchronous tick generator replacing ripple-style clock division in the irrigation controller. Runs entirely in the system clock domain and produces single-cycle enable pulses (`tick`) at a runtime-programmable period, an optional square wave, and a tick counter. Timers for valve scheduling and sensor sampling consume `tick` as a clock enable, never as a clock.

## Interface
- `DIV_W`, 26: width of divisor and internal counter.
- `DIV_DEFAULT`, 50_000_000: divisor after reset (1 Hz at 50 MHz); values 0 and 1 both act as 1.
- `CNT_W`, 16: width of `tick_cnt`.

- `clk` in 1: system clock, rising edge. One clock domain only.
- `rstn` in 1: synchronous, active-high reset.
- `en` in 1: level; 1 = run, 0 = idle.
- `restart` in 1: pulse; realigns phase.
- `div_val` in DIV_W: new divisor, sampled with `div_load`.
- `div_load` in 1: one-cycle load strobe.
- `div_ack` out 1: one-cycle pulse when the loaded divisor takes effect.
- `tick` out 1: one-cycle pulse per period.
- `sq_out` out 1: square wave at tick rate.
- `tick_cnt` out CNT_W: count of ticks issued.
- `running` out 1: state is RUN.

## Operation
- **Clamp:** `div_eff` = 1 when `div_cur` is 0, otherwise `div_cur`.
- **States:** IDLE and RUN.
  - IDLE → RUN on an edge with `en`=1; `cnt`←0.
  - RUN → IDLE on an edge with `en`=0; `cnt`←0, `tick`←0, `sq_out`←0.
- **RUN counting:**
  - Each edge: `cnt`←`cnt`+1.
  - Wrap edge (`cnt`==`div_eff`-1): `cnt`←0, `tick`←1 for one cycle, `tick_cnt`←`tick_cnt`+1.
  - `tick_cnt` wraps from all-ones to 0 and holds in IDLE.
- **Divisor load:**
  - In IDLE: `div_cur`←`div_val` at the strobe edge; `div_ack` pulses the next cycle.
  - In RUN: `div_val` is captured into a pending register, which is applied at the next wrap edge, RUN→IDLE edge, or `restart` edge. `div_ack` pulses in the cycle after application.
  - Repeated loads while pending: last value wins; exactly one `div_ack`.
  - Load on the wrap edge itself: the new value applies immediately for the next period; the wrap completes with the old value.
- **`restart` in RUN:** `cnt`←0, `sq_out`←0, no tick that edge, pending divisor applied, `tick_cnt`←0. Ignored in IDLE.
- **Priority:** `rstn` > `en`=0 > `restart` > wrap/count.
- **Reset values:** `tick`, `sq_out`, `div_ack`, `running`, `tick_cnt`, `cnt` all 0; state IDLE; `div_cur`=`DIV_DEFAULT`; no pending load.

## Timing
- **Registers:** all outputs are registered. There are no combinational input-to-output paths.
- **First tick:** if `en` is sampled at edge E0, `tick` is high after edge E0+`div_eff`. Thereafter the period is exactly `div_eff` cycles.
- **Divisor 1:** `tick` is high every RUN cycle.
- **`sq_out`:** while in RUN, each edge `sq_out`←(next `cnt` < ceil(`div_eff`/2)).
  - Odd divisors: high one cycle longer than low.
  - Divisor 1: constant 1.
- **`div_ack` latency:** 1 cycle after application edge.
- **`running` latency:** follows state with 0 extra latency (it is the state register).

## Configuration
- Macro `TICK_GEN_SQUARE_EN`.
  - Defined: `sq_out` is generated as above.
  - Undefined: the comparator and register are removed and `sq_out` is tied to 0; all other behaviour is unchanged.

## Structure
- Package `tick_gen_pkg`:
  - State enum `tick_state_t` {IDLE, RUN}.
  - Default divisor constant.
  - Helper for the clamp and half-period (ceil) computation.
- One natural sub-module, `tick_gen_div_reg`: holds the current and pending divisor, the pending flag, and `div_ack` generation. It exposes `div_eff` to the counter.

## Test plan
- **Reset and run:** reset, load 4 in IDLE, `en`=1 -> `div_ack` 1 cycle later; ticks at edges E0+4, +8, +12; `sq_out` pattern 1,1,0,0; `tick_cnt`=3.
- **Clamp:** `div_val`=0 and `div_val`=1 -> `tick` high every RUN cycle.
  - Square compiled in: `sq_out` stays 1.
  - Square compiled out: `sq_out` stays 0.
- **Mid-run load, last wins:** divisor 10, load 3 then 5 mid-period -> current period still 10 cycles; a single `div_ack` after the wrap; following periods 5 cycles.
- **Load on wrap edge:** divisor 6, `div_load`=2 on the wrap edge -> that tick is issued, next tick 2 cycles later.
- **Restart and `en` drop:**
  - `restart` at `cnt`=3 (divisor 8) -> no tick, next tick 8 cycles later, `tick_cnt`=0.
  - `en`=0 mid-period -> `running`=0, no further ticks, `tick_cnt` held.
- **Counter wrap:** `CNT_W`=4, divisor 1, 17 RUN cycles -> `tick_cnt` wraps 15->0 and ends at 1.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// tick_gen shared types, reset divisor and divisor helpers.
// Helpers work on 32-bit words; callers cast to their own width.
package tick_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tick_state_t;

    localparam int DEF_DIV = 50_000_000;

    typedef logic [31:0] div_word_t;

    function automatic div_word_t div_clamp(input div_word_t d);
        return (d == '0) ? 32'd1 : d;
    endfunction

    function automatic div_word_t div_half(input div_word_t d);
        div_word_t e;
        e = div_clamp(d);
        return (e >> 1) + {31'd0, e[0]};
    endfunction

endpackage

// File: rtl/tick_gen_div_reg.sv
// Current/pending divisor storage and div_ack generation.
// Loads in IDLE apply at once; loads in RUN wait for an apply edge.
module tick_gen_div_reg
    import tick_gen_pkg::*;
#(
    parameter int DIV_W       = 26,
    parameter int DIV_DEFAULT = DEF_DIV
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic             apply,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic [DIV_W-1:0] div_eff,
    output logic             div_ack
);

    logic [DIV_W-1:0] div_cur;
    logic [DIV_W-1:0] pend_val;
    logic             pend;

    always_ff @(posedge clk) begin
        if (rstn) begin
            div_cur  <= DIV_W'(DIV_DEFAULT);
            pend_val <= '0;
            pend     <= 1'b0;
            div_ack  <= 1'b0;
        end else begin
            div_ack <= 1'b0;
            if (!run) begin
                if (div_load) begin
                    div_cur <= div_val;
                    div_ack <= 1'b1;
                end
            end else if (apply && (div_load || pend)) begin
                // a strobe on the apply edge itself supersedes the pending value
                div_cur <= div_load ? div_val : pend_val;
                pend    <= 1'b0;
                div_ack <= 1'b1;
            end else if (div_load) begin
                pend_val <= div_val;
                pend     <= 1'b1;
            end
        end
    end

    assign div_eff = DIV_W'(div_clamp(32'(div_cur)));

endmodule

// File: rtl/tick_gen.sv
// Synchronous tick generator: enable pulses, tick counter, square wave.
// Square wave present only when TICK_GEN_SQUARE_EN is defined.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int DIV_W       = 26,
    parameter int DIV_DEFAULT = DEF_DIV,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             tick,
    output logic             sq_out,
    output logic [CNT_W-1:0] tick_cnt,
    output logic             running
);

    tick_state_t      state;
    tick_state_t      state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] div_eff;
    logic [CNT_W-1:0] tick_cnt_nxt;
    logic             tick_nxt;
    logic             wrap;
    logic             apply;

    tick_gen_div_reg #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_div_reg (
        .clk      (clk),
        .rstn     (rstn),
        .run      (running),
        .apply    (apply),
        .div_val  (div_val),
        .div_load (div_load),
        .div_eff  (div_eff),
        .div_ack  (div_ack)
    );

    assign running = (state == RUN);
    assign wrap    = (cnt == div_eff - DIV_W'(1));

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        tick_nxt     = 1'b0;
        tick_cnt_nxt = tick_cnt;
        apply        = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    apply     = 1'b1;
                end else if (restart) begin
                    cnt_nxt      = '0;
                    tick_cnt_nxt = '0;
                    apply        = 1'b1;
                end else if (wrap) begin
                    cnt_nxt      = '0;
                    tick_nxt     = 1'b1;
                    tick_cnt_nxt = tick_cnt + CNT_W'(1);
                    apply        = 1'b1;
                end else begin
                    cnt_nxt = cnt + DIV_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            tick     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tick     <= tick_nxt;
            tick_cnt <= tick_cnt_nxt;
        end
    end

`ifdef TICK_GEN_SQUARE_EN
    logic [DIV_W-1:0] half_eff;
    logic             sq_nxt;

    // high while the upcoming count sits in the first ceil(div/2) slots
    assign half_eff = DIV_W'(div_half(32'(div_eff)));
    assign sq_nxt   = running && en && !restart && (cnt_nxt < half_eff);

    always_ff @(posedge clk) begin
        if (rstn) begin
            sq_out <= 1'b0;
        end else begin
            sq_out <= sq_nxt;
        end
    end
`else
    assign sq_out = 1'b0;
`endif

endmodule
